// File: rtl/alu_seq_flags.sv
// alu_seq_flags: registered ALU for the SAP datapath.
//
// A start pulse in IDLE captures op/ACC/Breg. Add, subtract, carry-chained
// and logic ops finish in one edge. An unsigned multiply takes WIDTH
// shift-add edges. The result R, the product high half Rh and the flags
// {C,Z,N,V} are held in registers. Because C is held, ADC/SBB can chain
// multi-word arithmetic without losing the carry.
//
// Handshake: start is sampled on each rising CLK edge while busy is low,
// and is ignored while busy is high; nothing is queued. Every accepted
// start produces exactly one done pulse, one cycle wide. That pulse marks
// the cycle in which R, Rh and flags hold the new values. A start in the
// done cycle is accepted normally.
//
// Ports:
//   CLK        system clock; all state updates on the rising edge
//   CLR        synchronous active-high reset; aborts a running multiply
//   start      capture op/ACC/Breg on this edge (ignored while busy)
//   op[2:0]    000 ADD, 001 SUB, 010 ADC, 011 SBB, 100 AND, 101 OR,
//              110 XOR, 111 MUL (illegal when MUL_EN = 0)
//   ACC, Breg  operands A and B
//   Eu         1 = drive the W bus, 0 = W is high-impedance
//   hi_sel     1 = W shows Rh, 0 = W shows R
//   W          tri-state bus output, combinational from R/Rh
//   busy       multiply in progress
//   done       one-cycle pulse: R/flags were updated
//   flags      {C,Z,N,V}
//   dbg_state  current FSM state (0 = IDLE, 1 = MUL)
module alu_seq_flags #(
  parameter int WIDTH  = 8,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] ACC,
  input  logic [WIDTH-1:0] Breg,
  input  logic             Eu,
  input  logic             hi_sel,
  output logic [WIDTH-1:0] W,
  output logic             busy,
  output logic             done,
  output logic [3:0]       flags,
  output logic             dbg_state
);

  localparam int MSB = WIDTH - 1;
  localparam int CW  = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_ADC = 3'b010;
  localparam logic [2:0] OP_SBB = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic {S_IDLE = 1'b0, S_MUL = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] rh_q, rh_d;
  logic [3:0]       flags_q, flags_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] ma_q, ma_d;     // latched multiplicand
  logic [WIDTH-1:0] mhi_q, mhi_d;   // partial product, high half
  logic [WIDTH-1:0] mlo_q, mlo_d;   // multiplier shifting out / product low half
  logic [CW-1:0]    cnt_q, cnt_d;

  // Single-cycle ALU.
  logic [WIDTH:0]   alu_ext;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c, alu_v;
  logic [3:0]       alu_flags;

  always_comb begin
    alu_ext = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (op)
      OP_ADD: alu_ext = {1'b0, ACC} + {1'b0, Breg};
      OP_ADC: alu_ext = {1'b0, ACC} + {1'b0, Breg} + {{WIDTH{1'b0}}, flags_q[3]};
      OP_SUB: alu_ext = {1'b0, ACC} - {1'b0, Breg};
      OP_SBB: alu_ext = {1'b0, ACC} - {1'b0, Breg} - {{WIDTH{1'b0}}, flags_q[3]};
      OP_AND: alu_ext = {1'b0, ACC & Breg};
      OP_OR:  alu_ext = {1'b0, ACC | Breg};
      OP_XOR: alu_ext = {1'b0, ACC ^ Breg};
      default: alu_ext = '0;
    endcase
    alu_res = alu_ext[WIDTH-1:0];
    // Bit WIDTH is the carry for add-type ops. For subtract-type ops it is
    // the borrow: the difference wraps negative exactly when A < B(+C).
    if (op == OP_ADD || op == OP_ADC) begin
      alu_c = alu_ext[WIDTH];
      alu_v = (ACC[MSB] == Breg[MSB]) && (alu_res[MSB] != ACC[MSB]);
    end else if (op == OP_SUB || op == OP_SBB) begin
      alu_c = alu_ext[WIDTH];
      alu_v = (ACC[MSB] != Breg[MSB]) && (alu_res[MSB] != ACC[MSB]);
    end
    alu_flags = {alu_c, (alu_res == '0), alu_res[MSB], alu_v};
  end

  // One shift-add multiply step: optionally add A into the high half, then
  // shift the whole {carry, hi, lo} right by one.
  logic [WIDTH:0]   step_sum;
  logic [WIDTH-1:0] nxt_hi, nxt_lo;

  always_comb begin
    step_sum = {1'b0, mhi_q} + (mlo_q[0] ? {1'b0, ma_q} : '0);
    nxt_hi   = step_sum[WIDTH:1];
    nxt_lo   = {step_sum[0], mlo_q[WIDTH-1:1]};
  end

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    rh_d    = rh_q;
    flags_d = flags_q;
    done_d  = 1'b0;
    ma_d    = ma_q;
    mhi_d   = mhi_q;
    mlo_d   = mlo_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (op == OP_MUL) begin
            if (MUL_EN) begin
              ma_d    = ACC;
              mlo_d   = Breg;
              mhi_d   = '0;
              cnt_d   = '0;
              state_d = S_MUL;
            end else begin
              // Illegal op: acknowledge it, but leave results untouched.
              done_d = 1'b1;
            end
          end else begin
            r_d     = alu_res;
            flags_d = alu_flags;
            done_d  = 1'b1;
          end
        end
      end
      S_MUL: begin
        mhi_d = nxt_hi;
        mlo_d = nxt_lo;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_ITER) begin
          r_d     = nxt_lo;
          rh_d    = nxt_hi;
          flags_d = {(nxt_hi != '0), (nxt_hi == '0) && (nxt_lo == '0), nxt_lo[MSB], 1'b0};
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_q <= S_IDLE;
      r_q     <= '0;
      rh_q    <= '0;
      flags_q <= '0;
      done_q  <= 1'b0;
      ma_q    <= '0;
      mhi_q   <= '0;
      mlo_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      rh_q    <= rh_d;
      flags_q <= flags_d;
      done_q  <= done_d;
      ma_q    <= ma_d;
      mhi_q   <= mhi_d;
      mlo_q   <= mlo_d;
      cnt_q   <= cnt_d;
    end
  end

  assign W         = Eu ? (hi_sel ? rh_q : r_q) : {WIDTH{1'bz}};
  assign busy      = (state_q == S_MUL);
  assign done      = done_q;
  assign flags     = flags_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_seq_flags.sv
module tb_alu_seq_flags;

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] r;
    logic [3:0] f;
  } vec_t;

  logic       clk, clr, start, eu, hi_sel;
  logic [2:0] op;
  logic [7:0] acc, breg;
  wire  [7:0] w, w0;
  logic       busy, done, dbg, busy0, done0, dbg0;
  logic [3:0] flags, flags0;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];
  vec_t vecs[14];

  alu_seq_flags #(.WIDTH(8), .MUL_EN(1'b1)) dut (
    .CLK(clk), .CLR(clr), .start(start), .op(op), .ACC(acc), .Breg(breg),
    .Eu(eu), .hi_sel(hi_sel), .W(w), .busy(busy), .done(done),
    .flags(flags), .dbg_state(dbg)
  );

  alu_seq_flags #(.WIDTH(8), .MUL_EN(1'b0)) dut0 (
    .CLK(clk), .CLR(clr), .start(start), .op(op), .ACC(acc), .Breg(breg),
    .Eu(eu), .hi_sel(hi_sel), .W(w0), .busy(busy0), .done(done0),
    .flags(flags0), .dbg_state(dbg0)
  );

  // Clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected test to finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One single-cycle op; returns at the negedge after the capturing edge.
  task automatic do_op(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    op = o; acc = a; breg = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Multiply with a bounded wait for done; optionally inject a stray start.
  task automatic run_mul(input logic [7:0] a, input logic [7:0] b, input int stray_at,
                         output int busy_cycles, output bit got_done);
    @(negedge clk);
    op = 3'b111; acc = a; breg = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0; acc = 8'h55; breg = 8'h33;
    busy_cycles = 0;
    got_done    = 1'b0;
    for (int i = 0; i < 20 && !got_done; i++) begin
      if (busy) busy_cycles++;
      if (done) got_done = 1'b1;
      else begin
        if (i == stray_at) begin start = 1'b1; op = 3'b000; end
        else start = 1'b0;
        @(negedge clk);
      end
    end
    start = 1'b0;
  endtask

  initial begin
    int bc;
    bit gd;
    int late_done;
    logic [7:0] e;

    vecs[0]  = '{3'b000, 8'd15,  8'd5,   8'd20,  4'b0000};
    vecs[1]  = '{3'b001, 8'd3,   8'd5,   8'hFE,  4'b1010};
    vecs[2]  = '{3'b001, 8'd5,   8'd3,   8'd2,   4'b0000};
    vecs[3]  = '{3'b000, 8'h7F,  8'h01,  8'h80,  4'b0011};
    vecs[4]  = '{3'b000, 8'hFF,  8'h01,  8'h00,  4'b1100};
    vecs[5]  = '{3'b010, 8'h00,  8'h00,  8'h01,  4'b0000};
    vecs[6]  = '{3'b000, 8'hFF,  8'h01,  8'h00,  4'b1100};
    vecs[7]  = '{3'b011, 8'h05,  8'h05,  8'hFF,  4'b1010};
    vecs[8]  = '{3'b011, 8'h80,  8'h00,  8'h7F,  4'b0001};
    vecs[9]  = '{3'b100, 8'hF0,  8'h3C,  8'h30,  4'b0000};
    vecs[10] = '{3'b101, 8'h80,  8'h01,  8'h81,  4'b0010};
    vecs[11] = '{3'b110, 8'hAA,  8'hAA,  8'h00,  4'b0100};
    vecs[12] = '{3'b000, 8'h80,  8'h80,  8'h00,  4'b1101};
    vecs[13] = '{3'b010, 8'h01,  8'h01,  8'h03,  4'b0000};
    foreach (vecs[i]) exp_q.push_back(vecs[i].r);

    // Reset
    clr = 1'b1; start = 1'b0; op = 3'b000; acc = 8'h00; breg = 8'h00;
    eu = 1'b1; hi_sel = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 16'(busy), 16'h0);
    chk("rst_done", 16'(done), 16'h0);
    chk("rst_flags", 16'(flags), 16'h0);
    chk("rst_R", 16'(w), 16'h0);
    hi_sel = 1'b1; #1;
    chk("rst_Rh", 16'(w), 16'h0);
    hi_sel = 1'b0;
    clr = 1'b0;

    // Table of single-cycle ops, applied in order (ADC/SBB use the held C)
    for (int i = 0; i < 14; i++) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b);
      e = exp_q.pop_front();
      chk($sformatf("vec%0d_done", i), 16'(done), 16'h1);
      chk($sformatf("vec%0d_R", i), 16'(w), 16'(e));
      chk($sformatf("vec%0d_flags", i), 16'(flags), 16'(vecs[i].f));
      if (i == 0) begin
        @(negedge clk);
        chk("done_one_cycle", 16'(done), 16'h0);
        chk("flags_hold", 16'(flags), 16'h0);
        eu = 1'b0; #1;
        n_checks++;
        if (!(w === 8'hzz || w === 8'h00)) begin
          n_fail++;
          $display("FAIL W_hiz: got %h expected zz (not driven)", w);
        end
        eu = 1'b1; #1;
        chk("W_redrive", 16'(w), 16'd20);
      end
    end

    // MUL 15*17 = 255
    run_mul(8'd15, 8'd17, -1, bc, gd);
    chk("mul1_done", 16'(gd), 16'h1);
    chk("mul1_busy_cycles", 16'(bc), 16'd8);
    chk("mul1_R", 16'(w), 16'hFF);
    chk("mul1_flags", 16'(flags), 16'b0010);
    hi_sel = 1'b1; #1;
    chk("mul1_Rh", 16'(w), 16'h00);
    hi_sel = 1'b0;

    // MUL 16*16 = 256 with a stray start mid-multiply
    run_mul(8'd16, 8'd16, 3, bc, gd);
    chk("mul2_done", 16'(gd), 16'h1);
    chk("mul2_busy_cycles", 16'(bc), 16'd8);
    chk("mul2_R", 16'(w), 16'h00);
    chk("mul2_flags", 16'(flags), 16'b1000);
    hi_sel = 1'b1; #1;
    chk("mul2_Rh", 16'(w), 16'h01);
    @(negedge clk);
    chk("mul2_done_drop", 16'(done), 16'h0);

    // Non-MUL op leaves Rh alone
    do_op(3'b000, 8'd15, 8'd5);
    chk("add_keeps_Rh", 16'(w), 16'h01);
    hi_sel = 1'b0; #1;
    chk("add_after_mul_R", 16'(w), 16'd20);

    // Restore a non-zero state, then abort a multiply with CLR
    run_mul(8'd15, 8'd17, -1, bc, gd);
    @(negedge clk);
    op = 3'b111; acc = 8'd15; breg = 8'd17; start = 1'b1;
    @(negedge clk);                 // after edge k
    start = 1'b0;
    repeat (3) @(negedge clk);      // after edge k+3
    chk("abort_busy_before", 16'(busy), 16'h1);
    clr = 1'b1;
    @(negedge clk);                 // after edge k+4
    clr = 1'b0;
    chk("abort_busy", 16'(busy), 16'h0);
    chk("abort_done", 16'(done), 16'h0);
    chk("abort_flags", 16'(flags), 16'h0);
    chk("abort_R", 16'(w), 16'h00);
    hi_sel = 1'b1; #1;
    chk("abort_Rh", 16'(w), 16'h00);
    hi_sel = 1'b0;
    late_done = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) late_done++;
    end
    chk("abort_no_done", 16'(late_done), 16'h0);

    // MUL_EN = 0: op 111 pulses done and changes nothing
    do_op(3'b000, 8'h7F, 8'h01);
    chk("ill_prior_R", 16'(w0), 16'h80);
    do_op(3'b111, 8'd3, 8'd4);
    chk("ill_done", 16'(done0), 16'h1);
    chk("ill_busy", 16'(busy0), 16'h0);
    chk("ill_R", 16'(w0), 16'h80);
    chk("ill_flags", 16'(flags0), 16'b0011);
    hi_sel = 1'b1; #1;
    chk("ill_Rh", 16'(w0), 16'h00);
    hi_sel = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
